// File: rtl/rtc_param_sweep.sv
// Read sequencer for a multiplexed-bus RTC: sweeps a register list, captures each byte into a
// shadow bank and commits the bank atomically once the whole sweep has completed.
module rtc_param_sweep #(
  parameter int          N_REGS     = 9,
  parameter logic [N_REGS*8-1:0] ADDR_LIST =
    {8'h23, 8'h22, 8'h21, 8'h09, 8'h08, 8'h07, 8'h04, 8'h02, 8'h00},
  parameter int          PULSE_CYC  = 4,
  parameter bit          UIP_CHECK  = 1'b1,
  parameter logic [7:0]  UIP_ADDR   = 8'h0A,
  parameter bit          CONTINUOUS = 1'b0,
  localparam int         SEL_W      = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  up,
  input  logic                  down,
  input  logic [7:0]            Dato,
  output logic                  AD,
  output logic                  CS,
  output logic                  RD,
  output logic                  WR,
  output logic                  Dir_Dat,
  output logic [7:0]            Direccion,
  output logic [N_REGS*8-1:0]   regs_out,
  output logic [SEL_W-1:0]      sel,
  output logic [7:0]            sel_val,
  output logic                  busy,
  output logic                  done
);

  localparam int CYC_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(PULSE_CYC - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_REGS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UIP    = 3'd1;
  localparam logic [2:0] S_SWEEP  = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_ABORT  = 3'd4;
  localparam logic [2:0] S_FIRST  = UIP_CHECK ? S_UIP : S_SWEEP;

  logic [2:0]          state;
  logic [2:0]          ph;
  logic [CYC_W-1:0]    cyc;
  logic [SEL_W-1:0]    idx;
  logic                uip_wait;
  logic                uip_busy;
  logic                abort_pend;
  logic [N_REGS*8-1:0] shadow;
  logic [7:0]          cur_addr;
  logic                in_bus;
  logic                cyc_last;
  logic                capture;
  logic                abort_now;

  assign in_bus    = ((state == S_UIP) || (state == S_SWEEP)) && !uip_wait;
  assign cyc_last  = (cyc == CYC_LAST);
  assign capture   = in_bus && (ph == 3'd4) && cyc_last;
  assign abort_now = abort_pend || !en;
  assign busy      = (state != S_IDLE);

  always_comb begin
    cur_addr = UIP_ADDR;
    if (state == S_SWEEP) begin
      cur_addr = 8'h00;
      for (int i = 0; i < N_REGS; i++)
        if (idx == SEL_W'(i)) cur_addr = ADDR_LIST[8*i +: 8];
    end
  end

  // Strobes decode straight from the phase counter; idle values outside a bus cycle
  always_comb begin
    AD        = 1'b1;
    CS        = 1'b1;
    RD        = 1'b1;
    WR        = 1'b1;
    Dir_Dat   = 1'b0;
    Direccion = 8'h00;
    if (in_bus) begin
      Direccion = cur_addr;
      case (ph)
        3'd0: begin CS = 1'b0; AD = 1'b0; Dir_Dat = 1'b1; end
        3'd1: begin CS = 1'b0; Dir_Dat = 1'b1; end
        3'd2: CS = 1'b0;
        3'd3, 3'd4: begin CS = 1'b0; RD = 1'b0; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ph         <= 3'd0;
      cyc        <= '0;
      idx        <= '0;
      uip_wait   <= 1'b0;
      uip_busy   <= 1'b0;
      abort_pend <= 1'b0;
      done       <= 1'b0;
      shadow     <= '0;
      regs_out   <= '0;
    end else begin
      done <= 1'b0;
      // An enable drop is remembered so the running bus cycle still finishes cleanly
      if (busy && !en) abort_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          abort_pend <= 1'b0;
          ph         <= 3'd0;
          cyc        <= '0;
          idx        <= '0;
          uip_wait   <= 1'b0;
          if (en && (start || CONTINUOUS)) state <= S_FIRST;
        end
        S_UIP, S_SWEEP: begin
          if (uip_wait) begin
            if (cyc_last) begin
              cyc      <= '0;
              uip_wait <= 1'b0;
              if (abort_now) state <= S_ABORT;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end else begin
            if (capture) begin
              if (state == S_SWEEP) begin
                for (int i = 0; i < N_REGS; i++)
                  if (idx == SEL_W'(i)) shadow[8*i +: 8] <= Dato;
              end else begin
                uip_busy <= Dato[7];
              end
            end
            if (!cyc_last) begin
              cyc <= cyc + 1'b1;
            end else begin
              cyc <= '0;
              if (ph != 3'd5) begin
                ph <= ph + 3'd1;
              end else begin
                ph <= 3'd0;
                if (abort_now) begin
                  state <= S_ABORT;
                end else if (state == S_UIP) begin
                  if (uip_busy) begin
                    uip_wait <= 1'b1;
                  end else begin
                    state <= S_SWEEP;
                    idx   <= '0;
                  end
                end else if (idx == IDX_LAST) begin
                  state <= S_COMMIT;
                end else begin
                  idx <= idx + 1'b1;
                end
              end
            end
          end
        end
        S_COMMIT: begin
          regs_out   <= shadow;
          done       <= 1'b1;
          abort_pend <= 1'b0;
          idx        <= '0;
          ph         <= 3'd0;
          cyc        <= '0;
          state      <= (CONTINUOUS && en) ? S_FIRST : S_IDLE;
        end
        S_ABORT: begin
          abort_pend <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Browse pointer for the display path, independent of the sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= '0;
    end else if (up && !down) begin
      sel <= (sel == IDX_LAST) ? '0 : sel + 1'b1;
    end else if (down && !up) begin
      sel <= (sel == '0) ? IDX_LAST : sel - 1'b1;
    end
  end

  always_comb begin
    sel_val = 8'h00;
    for (int i = 0; i < N_REGS; i++)
      if (sel == SEL_W'(i)) sel_val = regs_out[8*i +: 8];
  end

endmodule

// File: tb/tb_rtc_param_sweep.sv
// Directed bench: three sequencer configurations (one-shot, UIP-guarded, continuous) driven by
// small RTC bus models; expected banks are queued at stimulus time and checked at each commit.
module tb_rtc_param_sweep;

  localparam logic [71:0] ADDR = {8'h23, 8'h22, 8'h21, 8'h09, 8'h08, 8'h07, 8'h04, 8'h02, 8'h00};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic en_a, start_a, up_a, down_a, ad_a, cs_a, rd_a, wr_a, dir_a, busy_a, done_a;
  logic [7:0] dato_a, addr_a, selv_a;
  logic [71:0] regs_a;
  logic [3:0] sel_a;

  logic en_u, start_u, ad_u, cs_u, rd_u, wr_u, dir_u, busy_u, done_u;
  logic [7:0] dato_u, addr_u, selv_u;
  logic [71:0] regs_u;
  logic [3:0] sel_u;

  logic en_c, start_c, ad_c, cs_c, rd_c, wr_c, dir_c, busy_c, done_c;
  logic [7:0] dato_c, addr_c, selv_c;
  logic [71:0] regs_c;
  logic [3:0] sel_c;

  logic zero = 1'b0;

  rtc_param_sweep #(.N_REGS(9), .ADDR_LIST(ADDR), .PULSE_CYC(2), .UIP_CHECK(1'b0),
                    .UIP_ADDR(8'h0A), .CONTINUOUS(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .start(start_a), .up(up_a), .down(down_a), .Dato(dato_a),
    .AD(ad_a), .CS(cs_a), .RD(rd_a), .WR(wr_a), .Dir_Dat(dir_a), .Direccion(addr_a),
    .regs_out(regs_a), .sel(sel_a), .sel_val(selv_a), .busy(busy_a), .done(done_a));

  rtc_param_sweep #(.N_REGS(9), .ADDR_LIST(ADDR), .PULSE_CYC(2), .UIP_CHECK(1'b1),
                    .UIP_ADDR(8'h0A), .CONTINUOUS(1'b0)) dut_u (
    .clk(clk), .rst(rst), .en(en_u), .start(start_u), .up(zero), .down(zero), .Dato(dato_u),
    .AD(ad_u), .CS(cs_u), .RD(rd_u), .WR(wr_u), .Dir_Dat(dir_u), .Direccion(addr_u),
    .regs_out(regs_u), .sel(sel_u), .sel_val(selv_u), .busy(busy_u), .done(done_u));

  rtc_param_sweep #(.N_REGS(9), .ADDR_LIST(ADDR), .PULSE_CYC(2), .UIP_CHECK(1'b0),
                    .UIP_ADDR(8'h0A), .CONTINUOUS(1'b1)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .start(start_c), .up(zero), .down(zero), .Dato(dato_c),
    .AD(ad_c), .CS(cs_c), .RD(rd_c), .WR(wr_c), .Dir_Dat(dir_c), .Direccion(addr_c),
    .regs_out(regs_c), .sel(sel_c), .sel_val(selv_c), .busy(busy_c), .done(done_c));

  // RTC bus models: latch the address while AD is low, return addr+0x10
  logic [7:0] lat_a = 8'h00, lat_u = 8'h00, lat_c = 8'h00;
  int uip_reads = 0;
  logic rd_prev_u = 1'b1;
  always @(posedge clk) begin
    if (!cs_a && !ad_a) lat_a <= addr_a;
    if (!cs_c && !ad_c) lat_c <= addr_c;
    if (!cs_u && !ad_u) lat_u <= addr_u;
    rd_prev_u <= rd_u;
    if (rd_u && !rd_prev_u && lat_u == 8'h0A) uip_reads <= uip_reads + 1;
  end
  assign dato_a = lat_a + 8'h10;
  assign dato_c = lat_c + 8'h10;
  assign dato_u = (lat_u == 8'h0A) ? ((uip_reads < 2) ? 8'h80 : 8'h00) : lat_u + 8'h10;

  // Protocol monitors
  int cslen_a = 0, windows_a = 0, badlen_a = 0, falls_a = 0, viol_a = 0, dones_a = 0;
  int windows_u = 0, dones_u = 0;
  logic csp_a = 1'b1, csp_u = 1'b1;
  always @(negedge clk) begin
    if (!cs_a && csp_a) falls_a <= falls_a + 1;
    if (cs_a && !csp_a) begin
      windows_a <= windows_a + 1;
      if (cslen_a != 10) badlen_a <= badlen_a + 1;
    end
    cslen_a <= cs_a ? 0 : cslen_a + 1;
    csp_a   <= cs_a;
    if (!rd_a && dir_a) viol_a <= viol_a + 1;
    if (done_a) dones_a <= dones_a + 1;
    if (cs_u && !csp_u) windows_u <= windows_u + 1;
    csp_u <= cs_u;
    if (done_u) dones_u <= dones_u + 1;
  end

  int total = 0;
  int bad = 0;
  logic [71:0] exp_q[$];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] exp_bank();
    logic [71:0] v;
    for (int i = 0; i < 9; i++) v[8*i +: 8] = ADDR[8*i +: 8] + 8'h10;
    return v;
  endfunction

  function automatic logic [71:0] pop_exp();
    if (exp_q.size() == 0) return 72'hx;
    return exp_q.pop_front();
  endfunction

  initial begin
    int n, base_w, base_d, base_f, base_v, base_b;
    logic seen;
    logic [71:0] bank;
    rst = 1'b1;
    en_a = 0; start_a = 0; up_a = 0; down_a = 0;
    en_u = 0; start_u = 0; en_c = 0; start_c = 0;
    step(); step();
    chk("rst_strobes", {ad_a, cs_a, rd_a, wr_a, dir_a}, 5'b11110);
    chk("rst_addr", addr_a, 8'h00);
    chk("rst_regs", regs_a, 72'h0);
    chk("rst_sel", sel_a, 4'd0);
    chk("rst_busy_done", {busy_a, done_a}, 2'b00);
    rst = 1'b0;

    start_a = 1;
    seen = 0;
    repeat (3) begin step(); if (busy_a) seen = 1; end
    start_a = 0;
    chk("no_en_busy", seen, 1'b0);

    // One-shot sweep with a stray start mid-sweep
    base_d = dones_a; base_w = windows_a; base_b = badlen_a; base_v = viol_a;
    en_a = 1; start_a = 1;
    exp_q.push_back(exp_bank());
    n = 0;
    while (!done_a && n < 400) begin
      step(); n++;
      start_a = (n == 50);
    end
    start_a = 0;
    chk("oneshot_latency", n, 110);
    bank = pop_exp();
    chk("oneshot_bank", regs_a, bank);
    chk("byte0", regs_a[7:0], 8'h10);
    chk("byte8", regs_a[71:64], 8'h33);
    step();
    chk("done_one_cycle", done_a, 1'b0);
    chk("idle_after_done", busy_a, 1'b0);
    step(); step();
    chk("cs_windows", windows_a - base_w, 9);
    chk("cs_window_len", badlen_a - base_b, 0);
    chk("rd_vs_dir", viol_a - base_v, 0);
    chk("done_count", dones_a - base_d, 1);

    // Browse pointer with en low
    en_a = 0;
    chk("selv0", selv_a, 8'h10);
    down_a = 1; step(); down_a = 0;
    chk("sel_down_wrap", sel_a, 4'd8);
    chk("selv8", selv_a, 8'h33);
    up_a = 1; step(); up_a = 0;
    chk("sel_up_wrap", sel_a, 4'd0);
    up_a = 1; down_a = 1; step(); up_a = 0; down_a = 0;
    chk("sel_both", sel_a, 4'd0);
    up_a = 1; step(); step(); up_a = 0;
    chk("sel_two", sel_a, 4'd2);
    chk("selv2", selv_a, 8'h14);

    // Abort during index 4, phase P2
    base_d = dones_a; base_w = windows_a; base_f = falls_a; base_b = badlen_a;
    en_a = 1; start_a = 1; step(); start_a = 0;
    n = 0;
    while (falls_a < base_f + 5 && n < 200) begin step(); n++; end
    while (dir_a && n < 200) begin step(); n++; end
    en_a = 0;
    while (busy_a && n < 300) begin step(); n++; end
    chk("abort_idle", busy_a, 1'b0);
    chk("abort_cs_high", cs_a, 1'b1);
    step(); step();
    chk("abort_windows", windows_a - base_w, 5);
    chk("abort_window_len", badlen_a - base_b, 0);
    chk("abort_no_done", dones_a - base_d, 0);
    chk("abort_regs_kept", regs_a, bank);

    // UIP-guarded sweep: two busy status reads, then clear
    en_u = 1; start_u = 1;
    exp_q.push_back(exp_bank());
    n = 0;
    while (!done_u && n < 400) begin step(); n++; start_u = 0; end
    chk("uip_latency", n, 150);
    chk("uip_bank", regs_u, pop_exp());
    step(); step(); step();
    chk("uip_reads", uip_reads, 3);
    chk("uip_done_count", dones_u, 1);
    chk("uip_windows", windows_u, 12);
    en_u = 0;

    // Continuous mode: back-to-back commits, then reset mid-sweep
    en_c = 1;
    exp_q.push_back(exp_bank());
    n = 0;
    while (!done_c && n < 400) begin step(); n++; end
    chk("cont_first_bank", regs_c, pop_exp());
    exp_q.push_back(exp_bank());
    n = 0;
    do begin step(); n++; end while (!done_c && n < 400);
    chk("cont_spacing", n, 109);
    chk("cont_second_bank", regs_c, pop_exp());
    repeat (30) step();
    chk("cont_busy_mid", busy_c, 1'b1);
    rst = 1'b1; en_c = 0;
    step();
    chk("midrst_strobes", {ad_c, cs_c, rd_c, wr_c, dir_c}, 5'b11110);
    chk("midrst_addr", addr_c, 8'h00);
    chk("midrst_busy_done", {busy_c, done_c}, 2'b00);
    chk("midrst_regs", regs_c, 72'h0);
    chk("midrst_sel_a", sel_a, 4'd0);
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
